// File: rtl/char2num_pkg.sv
// Shared state encoding, ASCII constants and character classification for char2num.
package char2num_pkg;

    localparam logic [1:0] s_idle  = 2'd0;
    localparam logic [1:0] s_accum = 2'd1;
    localparam logic [1:0] s_skip  = 2'd2;
    localparam logic [1:0] s_out   = 2'd3;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/char2num_mul10_add.sv
// acc*10 + digit as a shift-add, widened to 36 bits so overflow past 32 bits is visible.
module mul10_add (
    input  logic [31:0] acc,
    input  logic [3:0]  digit,
    output logic [31:0] next,
    output logic        ovf
);

    logic [35:0] acc36;
    logic [35:0] next36;

    always_comb begin
        acc36  = {4'b0, acc};
        next36 = (acc36 << 3) + (acc36 << 1) + {32'b0, digit};
        next   = next36[31:0];
        ovf    = |next36[35:32];
    end

endmodule

// File: rtl/char2num.sv
// Streaming ASCII-decimal to 32-bit unsigned converter; result one cycle after the terminator,
// ready drops for that single output cycle so a held character waits rather than being lost.
module char2num
    import char2num_pkg::*;
#(
    parameter int         MAX_DIGITS    = 10,
    parameter logic [7:0] TERM_CHAR     = ASCII_LF,
    parameter logic [7:0] ALT_TERM_CHAR = ASCII_CR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  char,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] num,
    output logic        valid_o,
    output logic        err_o
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [1:0]    state;
    logic [31:0]   acc;
    logic [CW-1:0] count;

    logic          accept;
    logic          digit_c;
    logic          term_c;
    logic [3:0]    digit;
    logic [31:0]   next;
    logic          ovf;

    always_comb begin
        accept  = valid_i && ready_o;
        digit_c = is_digit(char);
        term_c  = (char == TERM_CHAR) || (char == ALT_TERM_CHAR);
        // Digits 0x30..0x39 carry their value in the low nibble.
        digit   = char[3:0];
    end

    mul10_add u_mul10_add (
        .acc   (acc),
        .digit (digit),
        .next  (next),
        .ovf   (ovf)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= s_idle;
            acc   <= '0;
            count <= '0;
            num   <= '0;
            err_o <= 1'b0;
        end else begin
            case (state)
                s_idle: begin
                    if (accept) begin
                        if (digit_c) begin
                            acc   <= {28'b0, digit};
                            count <= CW'(1);
                            state <= s_accum;
                        end else if (!term_c) begin
                            state <= s_skip;
                        end
                    end
                end
                s_accum: begin
                    if (accept) begin
                        if (digit_c) begin
                            if (ovf || (count == CW'(MAX_DIGITS))) begin
                                state <= s_skip;
                            end else begin
                                acc   <= next;
                                count <= count + CW'(1);
                            end
                        end else if (term_c) begin
                            num   <= acc;
                            err_o <= 1'b0;
                            state <= s_out;
                        end else begin
                            state <= s_skip;
                        end
                    end
                end
                s_skip: begin
                    if (accept && term_c) begin
                        num   <= '0;
                        err_o <= 1'b1;
                        state <= s_out;
                    end
                end
                default: begin
                    acc   <= '0;
                    count <= '0;
                    state <= s_idle;
                end
            endcase
        end
    end

    always_comb begin
        valid_o = (state == s_out);
        ready_o = (state != s_out);
    end

endmodule

// File: tb/tb_char2num.sv
// Directed bench for char2num: inputs change at the falling edge, outputs are checked there too.
module tb_char2num;

    logic        CLK;
    logic        RST;
    logic [7:0]  char;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] num;
    logic        valid_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses_before;

    char2num dut (
        .CLK     (CLK),
        .RST     (RST),
        .char    (char),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .num     (num),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (valid_o) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present c, wait (bounded) for ready, let it be accepted, return at the next falling edge.
    task automatic send(input logic [7:0] c);
        char    = c;
        valid_i = 1'b1;
        for (int n = 0; n < 8 && !ready_o; n++) @(negedge CLK);
        if (!ready_o) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout observed %b expected 1", ready_o);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle();
        valid_i = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RST     = 1'b0;
        char    = 8'h00;
        valid_i = 1'b0;
        #1;
        chk("reset_num", num, 32'd0);
        chk("reset_valid", {31'b0, valid_o}, 32'd0);
        chk("reset_err", {31'b0, err_o}, 32'd0);
        chk("reset_ready", {31'b0, ready_o}, 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Largest representable value, streamed back-to-back.
        send_str("4294967295");
        send(8'h0A);
        chk("max_valid", {31'b0, valid_o}, 32'd1);
        chk("max_num", num, 32'hFFFFFFFF);
        chk("max_err", {31'b0, err_o}, 32'd0);
        idle();
        chk("max_valid_drop", {31'b0, valid_o}, 32'd0);

        // One past the maximum, terminated by CR.
        send_str("4294967296");
        send(8'h0D);
        chk("ovf_valid", {31'b0, valid_o}, 32'd1);
        chk("ovf_err", {31'b0, err_o}, 32'd1);
        chk("ovf_num", num, 32'd0);
        send_str("7");
        send(8'h0A);
        chk("seven_num", num, 32'd7);
        chk("seven_err", {31'b0, err_o}, 32'd0);
        idle();

        send_str("12a3");
        send(8'h0A);
        chk("alpha_valid", {31'b0, valid_o}, 32'd1);
        chk("alpha_err", {31'b0, err_o}, 32'd1);
        chk("alpha_num", num, 32'd0);
        idle();

        // Empty lines produce nothing.
        pulses_before = pulses;
        send(8'h0A);
        send(8'h0D);
        send(8'h0A);
        idle();
        idle();
        chk("empty_pulses", 32'(pulses), 32'(pulses_before));

        send_str("00000000001");
        send(8'h0A);
        chk("eleven_valid", {31'b0, valid_o}, 32'd1);
        chk("eleven_err", {31'b0, err_o}, 32'd1);
        chk("eleven_num", num, 32'd0);
        idle();

        send_str("0000000042");
        send(8'h0A);
        chk("ten_num", num, 32'd42);
        chk("ten_err", {31'b0, err_o}, 32'd0);
        idle();

        // valid_i stays high; the '9' must wait out the output cycle.
        send_str("5");
        send(8'h0A);
        chk("hold5_ready", {31'b0, ready_o}, 32'd0);
        chk("hold5_valid", {31'b0, valid_o}, 32'd1);
        chk("hold5_num", num, 32'd5);
        send_str("9");
        send(8'h0A);
        chk("hold9_ready", {31'b0, ready_o}, 32'd0);
        chk("hold9_num", num, 32'd9);
        chk("hold9_err", {31'b0, err_o}, 32'd0);
        idle();
        chk("hold9_ready_back", {31'b0, ready_o}, 32'd1);

        // Reset in the middle of a number discards the partial value.
        send_str("123");
        valid_i = 1'b0;
        RST     = 1'b0;
        #1;
        chk("midrst_num", num, 32'd0);
        chk("midrst_valid", {31'b0, valid_o}, 32'd0);
        chk("midrst_err", {31'b0, err_o}, 32'd0);
        chk("midrst_ready", {31'b0, ready_o}, 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send_str("45");
        send(8'h0A);
        chk("after_rst_num", num, 32'd45);
        chk("after_rst_err", {31'b0, err_o}, 32'd0);
        idle();
        idle();

        chk("total_pulses", 32'(pulses), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/char2num.md
Name: char2num

Overview:
- Streaming ASCII-decimal to binary converter; the receive-side counterpart of the number-to-character path.
- Consumes one 8-bit ASCII character per accepted handshake and accumulates decimal digits into a 32-bit unsigned value.
- On a line terminator it presents the value with a one-cycle valid pulse and an error flag.
- Sits behind the UART RX byte stream, feeding host-written numbers (thresholds, counts) to control logic.

Parameters:
- MAX_DIGITS, 10, maximum digit characters per number, leading zeros included.
- TERM_CHAR, 8'h0A, primary terminator (LF).
- ALT_TERM_CHAR, 8'h0D, secondary terminator (CR).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- char  input  8  ASCII character.
- valid_i  input  1  char valid; the character is accepted when valid_i && ready_o.
- ready_o  output  1  block can accept a character.
- num  output  32  converted value; holds until the next result.
- valid_o  output  1  one-cycle pulse, result available.
- err_o  output  1  qualifies valid_o: 1 means malformed or overflowed number.

Behaviour:
- Clock and reset: one clock CLK. Reset RST is asynchronous, active-low.
- Reset values: state=s_idle, acc=0, count=0, num=0, valid_o=0, err_o=0, ready_o=1.
- Character classes:
  - Digit: 8'h30..8'h39; digit value = char-8'h30.
  - Terminator: TERM_CHAR or ALT_TERM_CHAR.
  - Everything else is "other".
- States and transitions (evaluated only on accepted characters; otherwise hold):
  - s_idle (no digits yet):
    - digit -> acc=digit, count=1, go to s_accum.
    - terminator -> stay; empty lines produce no output.
    - other -> s_skip.
  - s_accum:
    - digit -> next = acc*10 + digit, computed in 36 bits as (acc<<3)+(acc<<1)+digit.
      - If next > 32'hFFFFFFFF or count==MAX_DIGITS -> s_skip.
      - Else acc=next[31:0], count+=1.
    - terminator -> num=acc, err_o=0, go to s_out.
    - other -> s_skip.
  - s_skip (error, discard rest of line):
    - terminator -> num=0, err_o=1, go to s_out.
    - digit/other -> discarded.
  - s_out: valid_o=1, ready_o=0 for exactly one cycle, then s_idle with acc=0, count=0.
- Outputs:
  - valid_o=1 only in s_out.
  - ready_o=0 only in s_out.
  - err_o is registered and meaningful only while valid_o=1; it holds its last value otherwise.
- Latency: terminator accepted at cycle N -> valid_o high at cycle N+1.
  - Next character acceptable at cycle N+2.
  - Minimum throughput: one result per (digits+2) cycles.
- Boundaries:
  - 4294967295 is accepted.
  - Any value ≥ 2^32 flags an error.
  - An 11th digit is an error even if all digits are zero.
- Stalls and handshake:
  - valid_i held high across s_out is not consumed until ready_o returns.
  - No character is ever lost or double-counted.
- Reset mid-number: asynchronous return to the reset values. Partial acc is discarded; no valid_o is produced for the aborted line.

Decomposition:
- Shared package:
  - State encoding: s_idle=2'd0, s_accum=2'd1, s_skip=2'd2, s_out=2'd3.
  - ASCII constants: ASCII_0=8'h30, ASCII_9=8'h39, ASCII_LF, ASCII_CR.
- One combinational sub-module, mul10_add:
  - Inputs: acc[31:0], digit[3:0].
  - Outputs: next[31:0] and ovf, where ovf = any of next36[35:32] set.
  - Keeps the shift-add and overflow check isolated and separately testable.
- FSM, counter and output registers stay in char2num.

Test Plan:
- "4294967295\n" streamed back-to-back -> one valid_o pulse, num=32'hFFFFFFFF, err_o=0, one cycle after LF accepted.
- "4294967296\r" -> valid_o pulse with err_o=1, num=0; then "7\n" -> num=7, err_o=0.
- "12a3\n" -> err_o=1, num=0. "\n\r\n" alone -> no valid_o pulse at all.
- "00000000001\n" (11 digits) -> err_o=1. "0000000042\n" (10 digits) -> num=42, err_o=0.
- valid_i held high continuously with "5\n9\n":
  - ready_o drops exactly one cycle after each terminator.
  - Results are 5 then 9; no character is dropped.
- Send "123", assert RST low for 1 cycle mid-stream, then send "45\n" -> num=45, err_o=0. All outputs read reset values while RST is low.
